// File: rtl/qspi_poll_sched_if.sv
// Bus bundle for the QSPI poll scheduler.
// Groups the host, poller and shifter-side signals of the block.
interface qspi_poll_sched_if;
    logic       host_cs;
    logic       host_start;
    logic [1:0] host_mode;
    logic       host_dir;
    logic [7:0] host_tx;
    logic       host_grant;
    logic       host_done;
    logic [7:0] host_rx;

    logic       poll_start;
    logic [7:0] poll_cmd;
    logic [7:0] poll_mask;
    logic       poll_busy;
    logic       poll_done;
    logic       poll_timeout;
    logic [7:0] poll_status;

    logic       sh_start;
    logic [1:0] sh_mode;
    logic       sh_dir;
    logic [7:0] sh_tx;
    logic       sh_busy;
    logic       sh_done;
    logic [7:0] sh_rx;

    logic       cs_out;

    modport master (
        output host_cs, host_start, host_mode, host_dir, host_tx,
        input  host_grant, host_done, host_rx,
        output poll_start, poll_cmd, poll_mask,
        input  poll_busy, poll_done, poll_timeout, poll_status,
        input  sh_start, sh_mode, sh_dir, sh_tx,
        output sh_busy, sh_done, sh_rx,
        input  cs_out
    );

    modport slave (
        input  host_cs, host_start, host_mode, host_dir, host_tx,
        output host_grant, host_done, host_rx,
        input  poll_start, poll_cmd, poll_mask,
        output poll_busy, poll_done, poll_timeout, poll_status,
        output sh_start, sh_mode, sh_dir, sh_tx,
        input  sh_busy, sh_done, sh_rx,
        output cs_out
    );
endinterface

// File: rtl/qspi_poll_sched.sv
// QSPI shifter arbiter between the FX2 host bridge and a flash
// status poller that repeats read-status until busy bits clear.
module qspi_poll_sched #(
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] POLL_MAX   = 16'd50000,
    parameter int               GAP_CYCLES = 8
) (
    input logic               FX_IFCLK,
    input logic               rst,
    qspi_poll_sched_if.slave  bus
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, HOST, P_CS, P_CMD, P_CMDW,
        P_RD, P_RDW, P_CHK, P_GAP, P_END
    } state_t;

    state_t           state, state_n;
    logic             pend;
    logic [7:0]       cmd_q;
    logic [7:0]       mask_q;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       status_q;
    logic             to_q;
    logic [GW-1:0]    gap_cnt;
    logic             clear;

    assign clear = (status_q & mask_q) == 8'h00;

    // State register, poll capture, status/counter and gap timer.
    always_ff @(posedge FX_IFCLK) begin
        if (rst) begin
            state    <= IDLE;
            pend     <= 1'b0;
            cmd_q    <= 8'h00;
            mask_q   <= 8'h00;
            cnt      <= '0;
            status_q <= 8'h00;
            to_q     <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            state <= state_n;
            if (bus.poll_start && !pend) begin
                pend   <= 1'b1;
                cmd_q  <= bus.poll_cmd;
                mask_q <= bus.poll_mask;
                cnt    <= '0;
                to_q   <= 1'b0;
            end else if (state == P_END) begin
                pend <= 1'b0;
            end
            if (state == P_RDW && bus.sh_done) begin
                status_q <= bus.sh_rx;
                if (cnt != '1)
                    cnt <= cnt + CNT_W'(1);
            end
            if (state == P_CHK) begin
                to_q    <= !clear;
                gap_cnt <= '0;
            end else if (state == P_GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end
        end
    end

    // Next state, CS ownership and shifter mux.
    always_comb begin
        state_n        = state;
        bus.cs_out     = 1'b0;
        bus.host_grant = 1'b0;
        bus.host_done  = 1'b0;
        bus.sh_start   = 1'b0;
        bus.sh_mode    = 2'b00;
        bus.sh_dir     = 1'b0;
        bus.sh_tx      = 8'h00;
        bus.poll_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.host_cs)
                    state_n = HOST;
                else if (pend)
                    state_n = P_CS;
            end
            HOST: begin
                bus.host_grant = 1'b1;
                bus.cs_out     = bus.host_cs;
                bus.sh_start   = bus.host_start;
                bus.sh_mode    = bus.host_mode;
                bus.sh_dir     = bus.host_dir;
                bus.sh_tx      = bus.host_tx;
                bus.host_done  = bus.sh_done;
                if (!bus.host_cs)
                    state_n = pend ? P_CS : IDLE;
            end
            P_CS: begin
                bus.cs_out = 1'b1;
                state_n    = P_CMD;
            end
            P_CMD: begin
                bus.cs_out = 1'b1;
                bus.sh_tx  = cmd_q;
                if (!bus.sh_busy) begin
                    bus.sh_start = 1'b1;
                    state_n      = P_CMDW;
                end
            end
            P_CMDW: begin
                bus.cs_out = 1'b1;
                if (bus.sh_done)
                    state_n = P_RD;
            end
            P_RD: begin
                bus.cs_out   = 1'b1;
                bus.sh_start = 1'b1;
                bus.sh_dir   = 1'b1;
                state_n      = P_RDW;
            end
            P_RDW: begin
                bus.cs_out = 1'b1;
                bus.sh_dir = 1'b1;
                if (bus.sh_done)
                    state_n = P_CHK;
            end
            P_CHK: begin
                bus.cs_out = 1'b1;
                if (clear)
                    state_n = P_END;
                else if (cnt == POLL_MAX)
                    state_n = P_END;
                else
                    state_n = P_GAP;
            end
            P_GAP: begin
                if (bus.host_cs)
                    state_n = HOST;
                else if (gap_cnt == GAP_LAST)
                    state_n = P_CS;
            end
            P_END: begin
                bus.poll_done = 1'b1;
                state_n       = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.host_rx      = bus.sh_rx;
    assign bus.poll_busy    = pend;
    assign bus.poll_status  = status_q;
    assign bus.poll_timeout = (state == P_END) && to_q;

endmodule

// File: tb/tb_qspi_poll_sched.sv
// Directed bench for qspi_poll_sched with a behavioural shifter.
// Inputs driven on the falling edge, outputs sampled there too.
module tb_qspi_poll_sched;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    qspi_poll_sched_if bus();

    qspi_poll_sched #(
        .CNT_W     (16),
        .POLL_MAX  (16'd4),
        .GAP_CYCLES(8)
    ) dut (
        .FX_IFCLK(clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  rx_mem [0:31];
    logic [10:0] st_log [0:127];
    int          gap_log [0:63];
    int          rx_i  = 0;
    int          bcnt  = 0;
    logic        cur_dir = 1'b0;
    int          n_start = 0;
    int          low_run = 0;
    int          gap_n   = 0;

    // Shifter model: 4-cycle byte, reads return rx_mem in order.
    always @(posedge clk) begin
        bus.sh_done <= 1'b0;
        if (rst) begin
            bus.sh_busy <= 1'b0;
            bcnt        <= 0;
        end else if (bus.sh_busy) begin
            if (bcnt == 0) begin
                bus.sh_busy <= 1'b0;
                bus.sh_done <= 1'b1;
                bus.sh_rx   <= cur_dir ? rx_mem[rx_i[4:0]] : 8'hFF;
                if (cur_dir)
                    rx_i <= rx_i + 1;
            end else begin
                bcnt <= bcnt - 1;
            end
        end else if (bus.sh_start) begin
            bus.sh_busy <= 1'b1;
            bcnt        <= 2;
            cur_dir     <= bus.sh_dir;
            st_log[n_start[6:0]] <= {bus.sh_mode, bus.sh_dir, bus.sh_tx};
            n_start     <= n_start + 1;
        end
    end

    // CS-low run lengths, logged at each CS rise.
    always @(posedge clk) begin
        if (rst) begin
            low_run <= 0;
        end else if (bus.cs_out) begin
            if (low_run > 0 && gap_n < 64) begin
                gap_log[gap_n[5:0]] <= low_run;
                gap_n <= gap_n + 1;
            end
            low_run <= 0;
        end else begin
            low_run <= low_run + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_hdone(input string tag, input logic [7:0] exp);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.host_done) seen = 1;
        end
        check({tag, "_done"}, seen, 1);
        if (seen) check({tag, "_rx"}, bus.host_rx, exp);
    endtask

    task automatic host_byte(input string tag, input logic [1:0] mode,
                             input logic dir, input logic [7:0] tx,
                             input logic [7:0] exp);
        bus.host_start = 1'b1;
        bus.host_mode  = mode;
        bus.host_dir   = dir;
        bus.host_tx    = tx;
        #1;
        check({tag, "_sh"},
              {bus.sh_start, bus.sh_mode, bus.sh_dir, bus.sh_tx},
              {1'b1, mode, dir, tx});
        @(negedge clk);
        bus.host_start = 1'b0;
        wait_hdone(tag, exp);
        check({tag, "_cs"}, bus.cs_out, 1);
    endtask

    task automatic start_poll(input logic [7:0] cmd, input logic [7:0] mask);
        bus.poll_start = 1'b1;
        bus.poll_cmd   = cmd;
        bus.poll_mask  = mask;
        @(negedge clk);
        bus.poll_start = 1'b0;
    endtask

    task automatic wait_starts(input string tag, input int target);
        for (int i = 0; i < 200 && n_start < target; i++)
            @(negedge clk);
        check({tag, "_starts"}, n_start >= target, 1);
    endtask

    task automatic wait_pdone(input string tag, input logic to,
                              input logic [7:0] st);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.poll_done) seen = 1;
        end
        check({tag, "_done"}, seen, 1);
        if (seen) begin
            check({tag, "_to"}, bus.poll_timeout, to);
            check({tag, "_st"}, bus.poll_status, st);
            check({tag, "_busy1"}, bus.poll_busy, 1);
            @(negedge clk);
            check({tag, "_busy0"}, bus.poll_busy, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int base, g0, n0, dn;
        for (int i = 0; i < 32; i++) rx_mem[i] = 8'h00;
        rx_mem[0]  = 8'hEF; rx_mem[1]  = 8'h40;
        rx_mem[2]  = 8'h03; rx_mem[3]  = 8'h03; rx_mem[4] = 8'h02;
        rx_mem[5]  = 8'h01; rx_mem[6]  = 8'h01;
        rx_mem[7]  = 8'h01; rx_mem[8]  = 8'h01;
        rx_mem[9]  = 8'h00;
        rx_mem[10] = 8'h01; rx_mem[11] = 8'h01;
        rx_mem[12] = 8'h01; rx_mem[13] = 8'h01;
        rx_mem[14] = 8'h00; rx_mem[15] = 8'hFF;

        rst            = 1'b1;
        bus.host_cs    = 1'b0;
        bus.host_start = 1'b0;
        bus.host_mode  = 2'b00;
        bus.host_dir   = 1'b0;
        bus.host_tx    = 8'h00;
        bus.poll_start = 1'b0;
        bus.poll_cmd   = 8'h00;
        bus.poll_mask  = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_grant", bus.host_grant, 0);
        check("rst_hdone", bus.host_done, 0);
        check("rst_pbusy", bus.poll_busy, 0);
        check("rst_pdone", {bus.poll_done, bus.poll_timeout}, 0);
        check("rst_pstat", bus.poll_status, 0);
        check("rst_cs", bus.cs_out, 0);
        check("rst_sh", {bus.sh_start, bus.sh_mode, bus.sh_dir, bus.sh_tx}, 0);
        rst = 1'b0;
        @(negedge clk);

        // host_start ignored while not granted
        bus.host_start = 1'b1;
        bus.host_tx    = 8'hA5;
        #1;
        check("ng_shstart", bus.sh_start, 0);
        @(negedge clk);
        bus.host_start = 1'b0;
        check("ng_nostart", n_start, 0);

        // host transaction: 0x9F out, two bytes in
        bus.host_cs = 1'b1;
        #1;
        check("h_grant0", bus.host_grant, 0);
        @(negedge clk);
        check("h_grant1", bus.host_grant, 1);
        check("h_cs1", bus.cs_out, 1);
        host_byte("h_b0", 2'b00, 1'b0, 8'h9F, 8'hFF);
        host_byte("h_b1", 2'b10, 1'b1, 8'h00, 8'hEF);
        host_byte("h_b2", 2'b10, 1'b1, 8'h00, 8'h40);
        bus.host_cs = 1'b0;
        #1;
        check("h_rel_cs", bus.cs_out, 0);
        @(negedge clk);
        check("h_rel_grant", bus.host_grant, 0);
        repeat (2) @(negedge clk);

        // three status reads, busy clears on the third
        base = n_start;
        g0   = gap_n;
        start_poll(8'h05, 8'h01);
        check("p3_busy", bus.poll_busy, 1);
        wait_pdone("p3", 1'b0, 8'h02);
        check("p3_nstart", n_start - base, 6);
        for (int r = 0; r < 3; r++) begin
            check($sformatf("p3_cmd%0d", r), st_log[base + 2*r],
                  {2'b00, 1'b0, 8'h05});
            check($sformatf("p3_rd%0d", r), st_log[base + 2*r + 1][10:8],
                  3'b001);
        end
        check("p3_ngap", gap_n - g0, 3);
        check("p3_gap1", gap_log[g0 + 1], 8);
        check("p3_gap2", gap_log[g0 + 2], 8);

        // iteration limit
        base = n_start;
        start_poll(8'h05, 8'h01);
        wait_pdone("pto", 1'b1, 8'h01);
        check("pto_nstart", n_start - base, 8);

        // host wins a same-cycle request, poll follows
        bus.host_cs    = 1'b1;
        bus.poll_start = 1'b1;
        bus.poll_cmd   = 8'h05;
        bus.poll_mask  = 8'h01;
        @(negedge clk);
        bus.poll_start = 1'b0;
        check("pr_grant", bus.host_grant, 1);
        check("pr_busy", bus.poll_busy, 1);
        check("pr_cs", bus.cs_out, 1);
        repeat (2) @(negedge clk);
        bus.host_cs = 1'b0;
        #1;
        check("pr_gapcs", bus.cs_out, 0);
        @(negedge clk);
        check("pr_pcs", {bus.host_grant, bus.cs_out}, 2'b01);
        wait_pdone("pr", 1'b0, 8'h00);

        // host preempts the gap after read 2
        base = n_start;
        start_poll(8'h05, 8'h01);
        wait_starts("pe", base + 4);
        for (int i = 0; i < 40 && bus.cs_out; i++)
            @(negedge clk);
        check("pe_ingap", {bus.cs_out, bus.host_grant}, 0);
        bus.host_cs = 1'b1;
        @(negedge clk);
        check("pe_grant", {bus.host_grant, bus.cs_out}, 2'b11);
        n0 = n_start;
        repeat (12) @(negedge clk);
        check("pe_quiet", n_start - n0, 0);
        check("pe_busy", bus.poll_busy, 1);
        bus.host_cs = 1'b0;
        wait_pdone("pe", 1'b1, 8'h01);
        check("pe_nstart", n_start - base, 8);
        check("pe_resume", st_log[base + 4], {2'b00, 1'b0, 8'h05});

        // reset during a status read
        base = n_start;
        start_poll(8'h05, 8'h01);
        wait_starts("rs", base + 2);
        rst = 1'b1;
        @(negedge clk);
        check("rs_cs", bus.cs_out, 0);
        check("rs_busy", bus.poll_busy, 0);
        check("rs_done", bus.poll_done, 0);
        rst = 1'b0;
        dn  = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.poll_done) dn++;
        end
        check("rs_nodone", dn, 0);

        // fresh poll after reset, with start latency
        base = n_start;
        bus.poll_start = 1'b1;
        bus.poll_cmd   = 8'h05;
        bus.poll_mask  = 8'h01;
        @(negedge clk);
        bus.poll_start = 1'b0;
        check("lat1", {bus.poll_busy, bus.cs_out}, 2'b10);
        @(negedge clk);
        check("lat2", bus.cs_out, 1);
        wait_pdone("rs2", 1'b0, 8'h00);
        check("rs2_nstart", n_start - base, 2);

        // zero mask completes on the first read
        base = n_start;
        start_poll(8'h05, 8'h00);
        wait_pdone("m0", 1'b0, 8'hFF);
        check("m0_nstart", n_start - base, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
